lvds_rx_deser: RTL and testbench

//  Serial-to-parallel receiver directly downstream of the LVDS differential input buffer.

---
 rtl/lvds_rx_pkg.sv | 26 ++
 rtl/lvds_rx_deser_if.sv | 14 +
 rtl/lvds_rx_sync.sv | 23 ++
 rtl/lvds_rx_deser.sv | 163 ++++++++++++++++
 tb/tb_lvds_rx_deser.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared types, default constants and counter-width helpers for the LVDS word deserialiser.
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  localparam int         DEF_WIDTH         = 8;
  localparam int         DEF_SYNC_STAGES   = 2;
  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'h6A;
  localparam int         DEF_LOCK_COUNT    = 4;
  localparam int         DEF_LOS_WORDS     = 16;

  // Bits needed to count 0..n-1 (never narrower than one bit).
  function automatic int bit_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold 0..lock_count inclusive.
  function automatic int match_cnt_w(input int lock_count);
    return $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/lvds_rx_deser_if.sv
// Receiver-side signal bundle: serial input plus aligned word, strobe and status outputs.
interface lvds_rx_deser_if #(
  parameter int WIDTH = 8
);
  logic             d;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             locked;
  logic             align_err;

  // master drives the serial line and observes the results; slave is the deserialiser
  modport master (output d, input q, q_valid, locked, align_err);
  modport slave  (input d, output q, q_valid, locked, align_err);
endinterface

// File: rtl/lvds_rx_sync.sv
// Flop-chain synchroniser bringing the buffer output into the clk domain; async reset to 0.
module lvds_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic d_s
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign d_s = chain_reg[STAGES-1];

endmodule

// File: rtl/lvds_rx_deser.sv
// Serial-to-parallel LVDS receiver: hunts for the training word, verifies alignment, then strobes words.
// Optional loss-of-signal unlock is enabled by defining LVDS_RX_LOSS_DETECT_EN.
module lvds_rx_deser
  import lvds_rx_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEF_TRAIN_PATTERN),
  parameter int               LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int               LOS_WORDS     = DEF_LOS_WORDS
) (
  input logic            clk,
  input logic            rst,
  lvds_rx_deser_if.slave bus
);

  localparam int BCW = bit_cnt_w(WIDTH);
  localparam int MCW = match_cnt_w(LOCK_COUNT);
  localparam logic [BCW-1:0] LAST_BIT    = BCW'(WIDTH - 1);
  localparam logic [MCW-1:0] LOCK_TARGET = MCW'(LOCK_COUNT);

  if (WIDTH < 4 || SYNC_STAGES < 2 || LOCK_COUNT < 2 || LOS_WORDS < 1) begin : g_bad_params
    $error("lvds_rx_deser: parameter out of range");
  end

  logic             d_s;
  logic [WIDTH-1:0] sr_reg;
  logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [MCW-1:0]   match_cnt_reg, match_cnt_next;
  rx_state_t        state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;
  logic             locked_reg, locked_next;
  logic             align_err_reg, align_err_next;
  logic             boundary;
  logic             train_hit;

  lvds_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.d),
    .d_s (d_s)
  );

  // Case equality so that an X/Z bit in the window can never count as a match.
  assign train_hit = (sr_reg === TRAIN_PATTERN);
  assign boundary  = (bit_cnt_reg == LAST_BIT);

`ifdef LVDS_RX_LOSS_DETECT_EN
  localparam int LCW = bit_cnt_w(LOS_WORDS);
  localparam logic [LCW-1:0] LOS_LAST = LCW'(LOS_WORDS - 1);

  logic [LCW-1:0] los_cnt_reg, los_cnt_next;
  logic           word_const;

  assign word_const = (sr_reg === '0) || (sr_reg === '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      los_cnt_reg <= '0;
    end else begin
      los_cnt_reg <= los_cnt_next;
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = boundary ? '0 : bit_cnt_reg + BCW'(1);
    match_cnt_next = match_cnt_reg;
    q_next         = q_reg;
    q_valid_next   = 1'b0;
    align_err_next = 1'b0;
`ifdef LVDS_RX_LOSS_DETECT_EN
    los_cnt_next   = los_cnt_reg;
`endif

    case (state_reg)
      HUNT: begin
        // Restart the word phase so the next boundary lands one full word after the match.
        if (train_hit) begin
          bit_cnt_next   = '0;
          match_cnt_next = MCW'(1);
          state_next     = VERIFY;
        end
      end

      VERIFY: begin
        if (boundary) begin
          if (train_hit) begin
            if (match_cnt_reg + MCW'(1) == LOCK_TARGET) begin
              match_cnt_next = LOCK_TARGET;
              state_next     = LOCKED;
            end else begin
              match_cnt_next = match_cnt_reg + MCW'(1);
            end
          end else begin
            align_err_next = 1'b1;
            match_cnt_next = '0;
            state_next     = HUNT;
          end
        end
      end

      LOCKED: begin
        if (boundary) begin
`ifdef LVDS_RX_LOSS_DETECT_EN
          // The word that completes the constant run is dropped rather than strobed.
          if (word_const && los_cnt_reg == LOS_LAST) begin
            state_next     = HUNT;
            match_cnt_next = '0;
            los_cnt_next   = '0;
          end else begin
            q_next       = sr_reg;
            q_valid_next = 1'b1;
            los_cnt_next = word_const ? los_cnt_reg + LCW'(1) : '0;
          end
`else
          q_next       = sr_reg;
          q_valid_next = 1'b1;
`endif
        end
      end

      default: begin
        state_next     = HUNT;
        match_cnt_next = '0;
      end
    endcase

    locked_next = (state_next == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg        <= '0;
      bit_cnt_reg   <= '0;
      match_cnt_reg <= '0;
      state_reg     <= HUNT;
      q_reg         <= '0;
      q_valid_reg   <= 1'b0;
      locked_reg    <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      sr_reg        <= {sr_reg[WIDTH-2:0], d_s};
      bit_cnt_reg   <= bit_cnt_next;
      match_cnt_reg <= match_cnt_next;
      state_reg     <= state_next;
      q_reg         <= q_next;
      q_valid_reg   <= q_valid_next;
      locked_reg    <= locked_next;
      align_err_reg <= align_err_next;
    end
  end

  assign bus.q         = q_reg;
  assign bus.q_valid   = q_valid_reg;
  assign bus.locked    = locked_reg;
  assign bus.align_err = align_err_reg;

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Self-checking bench for lvds_rx_deser: scenario table plus hand-written reset and loss-of-signal sequences.
module tb_lvds_rx_deser;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic clk;
  logic rst;

  lvds_rx_deser_if #(.WIDTH(W)) bus();

  lvds_rx_deser #(
    .WIDTH         (W),
    .SYNC_STAGES   (SYNC),
    .TRAIN_PATTERN (8'h6A),
    .LOCK_COUNT    (4),
    .LOS_WORDS     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_strobe = -1;
  int         err_seen = 0;
  int         pending_watch = 0;
  string      cur_case = "init";
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  typedef struct {
    string      name;
    int         junk_n;
    logic [7:0] junk;
    int         n_pre;
    logic [7:0] pre [3];
    int         exp_err;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;

  vec_t vecs [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_case, name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest word pushed when it was driven.
  always @(negedge clk) begin
    if (rst) begin
      last_strobe = -1;
    end else begin
      if (bus.q_valid) begin
        chk("strobe_while_locked", bus.locked, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", bus.q_valid, 0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("q_word", bus.q, exp_w);
        end
        if (last_strobe >= 0) chk("strobe_spacing", cyc - last_strobe, W);
        last_strobe = cyc;
      end
      if (bus.align_err) err_seen++;
    end
  end

  task automatic send_bit(input logic b);
    bus.d = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit push);
    if (push) exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // Entered 1ns after the edge that sampled the last bit of a key word; checks the status
  // change lands exactly SYNC_STAGES+1 edges later (one cycle after the word boundary).
  task automatic watch(input int which);
    logic b_lock, b_err, a_lock, a_err, a_qv;
    if (which == 0) return;
    repeat (SYNC) @(posedge clk);
    #1;
    b_lock = bus.locked;
    b_err  = bus.align_err;
    @(posedge clk);
    #1;
    a_lock = bus.locked;
    a_err  = bus.align_err;
    a_qv   = bus.q_valid;
    case (which)
      1: begin
        chk("lock_before_boundary", b_lock, 0);
        chk("lock_rise", a_lock, 1);
      end
      2: begin
        chk("err_before_boundary", b_err, 0);
        chk("err_pulse", a_err, 1);
        chk("unlocked_after_err", a_lock, 0);
        @(posedge clk);
        #1;
        chk("err_one_cycle", bus.align_err, 0);
      end
`ifdef LVDS_RX_LOSS_DETECT_EN
      3: begin
        chk("los_before_boundary", b_lock, 1);
        chk("los_drop", a_lock, 0);
        chk("los_no_strobe", a_qv, 0);
      end
`endif
      default: ;
    endcase
  endtask

  task automatic tx(input logic [7:0] w, input bit push, input int wsel);
    int pw;
    pw = pending_watch;
    fork
      watch(pw);
      send_word(w, push);
    join
    pending_watch = wsel;
  endtask

  task automatic do_reset(input bit check_outputs);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus.d = i[0];
      @(negedge clk);
      if (check_outputs) begin
        chk("reset_outputs", {bus.q, bus.q_valid, bus.locked, bus.align_err}, 0);
        chk("reset_no_x", $isunknown({bus.q, bus.q_valid, bus.locked, bus.align_err}), 0);
      end
      @(posedge clk);
      #1;
    end
    bus.d = 1'b0;
    rst = 1'b0;
    err_seen = 0;
    pending_watch = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic lock_seq();
    tx(8'h00, 0, 0);
    tx(8'h00, 0, 0);
    for (int t = 0; t < 4; t++) tx(8'h6A, 0, (t == 3) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    bus.d = 1'b0;

    cur_case = "reset";
    do_reset(1);

    vecs[0] = '{"lock_basic",  0, 8'h00,    0, '{8'h00, 8'h00, 8'h00}, 0, 8'hA5, 8'h6A};
    vecs[1] = '{"bit_offset3", 3, 8'b101,   0, '{8'h00, 8'h00, 8'h00}, 0, 8'h3C, 8'hC3};
    vecs[2] = '{"verify_fail", 0, 8'h00,    3, '{8'h6A, 8'h6A, 8'h6B}, 1, 8'h81, 8'h7E};
    vecs[3] = '{"bit_offset5", 5, 8'b11011, 0, '{8'h00, 8'h00, 8'h00}, 0, 8'hFF, 8'h01};

    for (int v = 0; v < 4; v++) begin
      cur_case = vecs[v].name;
      do_reset(0);
      tx(8'h00, 0, 0);
      tx(8'h00, 0, 0);
      for (int j = vecs[v].junk_n - 1; j >= 0; j--) send_bit(vecs[v].junk[j]);
      for (int p = 0; p < vecs[v].n_pre; p++)
        tx(vecs[v].pre[p], 0, (p == vecs[v].n_pre - 1 && vecs[v].exp_err != 0) ? 2 : 0);
      for (int t = 0; t < 4; t++) tx(8'h6A, 0, (t == 3) ? 1 : 0);
      tx(vecs[v].d0, 1, 0);
      tx(vecs[v].d1, 1, 0);
      tx(8'h00, 1, 0);
      drain();
      chk("locked_hold", bus.locked, 1);
      chk("align_err_count", err_seen, vecs[v].exp_err);
    end

    // Reset in the middle of a word while locked, then a full retrain.
    cur_case = "rst_midlock";
    do_reset(0);
    lock_seq();
    tx(8'h99, 1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("pre_locked", bus.locked, 1);
    chk("pre_q", bus.q, 8'h99);
    chk("pre_pending", exp_q.size(), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_q", bus.q, 0);
    chk("rst_q_valid", bus.q_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_align_err", bus.align_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.d = 1'b0;
    rst = 1'b0;
    tx(8'h00, 0, 0);
    for (int t = 0; t < 3; t++) tx(8'h6A, 0, 0);
    chk("no_lock_after_3", bus.locked, 0);
    tx(8'h6A, 0, 1);
    tx(8'h42, 1, 0);
    tx(8'h00, 1, 0);
    drain();
    chk("relocked", bus.locked, 1);
    chk("align_err_count", err_seen, 0);

`ifdef LVDS_RX_LOSS_DETECT_EN
    cur_case = "los_16";
    do_reset(0);
    lock_seq();
    for (int k = 0; k < 16; k++) tx(8'h00, (k < 15), (k == 15) ? 3 : 0);
    watch(pending_watch);
    pending_watch = 0;
    drain();
    chk("los_stays_unlocked", bus.locked, 0);
    chk("los_q_hold", bus.q, 8'h00);

    cur_case = "los_15";
    do_reset(0);
    lock_seq();
    for (int k = 0; k < 15; k++) tx(8'h00, 1, 0);
    tx(8'h5A, 1, 0);
    tx(8'h00, 1, 0);
    drain();
    chk("los15_locked", bus.locked, 1);
`else
    cur_case = "no_los";
    do_reset(0);
    lock_seq();
    for (int k = 0; k < 16; k++) tx(8'h00, 1, 0);
    tx(8'h5A, 1, 0);
    tx(8'h00, 1, 0);
    drain();
    chk("locked_without_los", bus.locked, 1);
    chk("q_last_word", bus.q, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
